// File: rtl/samcoupe_ps2_keyboard_if.sv
// PS/2 keyboard front end bus: PS/2 pins in, ASIC matrix read and flags out.
interface samcoupe_ps2_keyboard_if;
  logic        ps2_kbd_clk;
  logic        ps2_kbd_data;
  logic [15:0] addr;
  logic [7:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;
  logic        kbd_err;

  // ASIC / host side
  modport master (
    output ps2_kbd_clk, ps2_kbd_data, addr,
    input  key_data, Fn, mod, kbd_err
  );

  // Keyboard front end
  modport slave (
    input  ps2_kbd_clk, ps2_kbd_data, addr,
    output key_data, Fn, mod, kbd_err
  );
endinterface

// File: rtl/samcoupe_ps2_keyboard.sv
// SAM Coupe PS/2 keyboard front end: PS/2 receiver, make/break decode and
// key matrix (8 half-rows plus extra row) read combinationally by the ASIC.
module samcoupe_ps2_keyboard #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  samcoupe_ps2_keyboard_if.slave  bus
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [5:0] pos;
  } mat_key_t;

  // Matrix position of a key: half-row 0 (A8) .. 7 (A15), bit 0..4
  function automatic mat_key_t mk(input int unsigned row, input int unsigned col);
    mat_key_t k;
    k.hit = 1'b1;
    k.pos = 6'(row * 5 + col);
    return k;
  endfunction

  // ---------------------------------------------------------------- input sync
  logic [1:0] clk_sync, data_sync;
  logic       clk_s, data_s;

  // Two-stage synchronisers for the asynchronous PS/2 pins
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_kbd_clk};
      data_sync <= {data_sync[0], bus.ps2_kbd_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // ---------------------------------------------------------- clock filtering
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          edge_stb, fall_stb;

  assign edge_stb = (clk_s != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall_stb = edge_stb && !clk_s;

  // Accept a PS/2 clock level change only once it has been stable long enough
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (edge_stb) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------- receiver FSM
  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          byte_stb, err_stb;
  logic          byte_valid, kbd_err_q;
  logic [WW-1:0] wd_cnt;
  logic          wd_expired;

  assign wd_expired = (state_q != ST_IDLE) && (wd_cnt == WW'(TIMEOUT));

  // Watchdog: cycles since the last accepted clock edge while a frame is open
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (edge_stb || state_q == ST_IDLE) begin
      wd_cnt <= '0;
    end else if (!wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Receiver state and frame registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      byte_valid <= 1'b0;
      kbd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      byte_valid <= byte_stb;
      kbd_err_q  <= err_stb;
    end
  end

  // Frame sequencing on filtered falling edges; watchdog abandons partial frames
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    byte_stb  = 1'b0;
    err_stb   = 1'b0;
    if (wd_expired && !fall_stb) begin
      state_d = ST_IDLE;
    end else if (fall_stb) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (data_s && (^{shreg_q, par_q})) byte_stb = 1'b1;
          else                               err_stb  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------- scan code decode
  logic        rel_q, ext_q;
  logic [2:0]  skip_q;
  logic [39:0] held;       // pressed keys in the half-rows, bits 4:0
  logic [11:1] fn_q;
  logic [5:0]  mod_held;   // {alt_r, alt_l, ctrl_r, ctrl_l, shift_r, shift_l}
  logic [3:0]  arrows;     // {right, left, down, up}

  mat_key_t    mkey;
  logic [39:0] held_mask;
  logic [11:1] fn_hit;
  logic [5:0]  mod_hit;
  logic [3:0]  arrow_hit;

  // Map the received byte (with E0 prefix state) onto the key it affects
  always_comb begin
    mkey      = '0;
    fn_hit    = '0;
    mod_hit   = '0;
    arrow_hit = '0;
    if (ext_q) begin
      case (shreg_q)
        8'h75: arrow_hit[0] = 1'b1;
        8'h72: arrow_hit[1] = 1'b1;
        8'h6B: arrow_hit[2] = 1'b1;
        8'h74: arrow_hit[3] = 1'b1;
        8'h14: mod_hit[3]   = 1'b1;
        8'h11: mod_hit[5]   = 1'b1;
        8'h5A: mkey         = mk(6, 0);
        default: ;
      endcase
    end else begin
      case (shreg_q)
        8'h12: mod_hit[0] = 1'b1;
        8'h59: mod_hit[1] = 1'b1;
        8'h14: mod_hit[2] = 1'b1;
        8'h11: mod_hit[4] = 1'b1;
        8'h1A: mkey = mk(0, 1);  8'h22: mkey = mk(0, 2);
        8'h21: mkey = mk(0, 3);  8'h2A: mkey = mk(0, 4);
        8'h1C: mkey = mk(1, 0);  8'h1B: mkey = mk(1, 1);
        8'h23: mkey = mk(1, 2);  8'h2B: mkey = mk(1, 3);
        8'h34: mkey = mk(1, 4);
        8'h15: mkey = mk(2, 0);  8'h1D: mkey = mk(2, 1);
        8'h24: mkey = mk(2, 2);  8'h2D: mkey = mk(2, 3);
        8'h2C: mkey = mk(2, 4);
        8'h16: mkey = mk(3, 0);  8'h1E: mkey = mk(3, 1);
        8'h26: mkey = mk(3, 2);  8'h25: mkey = mk(3, 3);
        8'h2E: mkey = mk(3, 4);
        8'h45: mkey = mk(4, 0);  8'h46: mkey = mk(4, 1);
        8'h3E: mkey = mk(4, 2);  8'h3D: mkey = mk(4, 3);
        8'h36: mkey = mk(4, 4);
        8'h4D: mkey = mk(5, 0);  8'h44: mkey = mk(5, 1);
        8'h43: mkey = mk(5, 2);  8'h3C: mkey = mk(5, 3);
        8'h35: mkey = mk(5, 4);
        8'h5A: mkey = mk(6, 0);  8'h4B: mkey = mk(6, 1);
        8'h42: mkey = mk(6, 2);  8'h3B: mkey = mk(6, 3);
        8'h33: mkey = mk(6, 4);
        8'h29: mkey = mk(7, 0);  8'h3A: mkey = mk(7, 2);
        8'h31: mkey = mk(7, 3);  8'h32: mkey = mk(7, 4);
        8'h05: fn_hit[1]  = 1'b1;
        8'h06: fn_hit[2]  = 1'b1;
        8'h04: fn_hit[3]  = 1'b1;
        8'h0C: fn_hit[4]  = 1'b1;
        8'h03: fn_hit[5]  = 1'b1;
        8'h0B: fn_hit[6]  = 1'b1;
        8'h83: fn_hit[7]  = 1'b1;
        8'h0A: fn_hit[8]  = 1'b1;
        8'h01: fn_hit[9]  = 1'b1;
        8'h09: fn_hit[10] = 1'b1;
        8'h78: fn_hit[11] = 1'b1;
        default: ;
      endcase
    end
    held_mask = mkey.hit ? (40'd1 << mkey.pos) : '0;
  end

  // Apply prefixes and make/break to the held-key state.
  // Held keys are stored per key (not per matrix bit); the matrix is derived,
  // so each shift/ctrl/alt side releases independently of the other.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rel_q    <= 1'b0;
      ext_q    <= 1'b0;
      skip_q   <= '0;
      held     <= '0;
      fn_q     <= '0;
      mod_held <= '0;
      arrows   <= '0;
    end else if (byte_valid) begin
      if (skip_q != 3'd0) begin
        skip_q <= skip_q - 1'b1;
      end else if (shreg_q == 8'hF0) begin
        rel_q <= 1'b1;
      end else if (shreg_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else begin
        rel_q <= 1'b0;
        ext_q <= 1'b0;
        if (shreg_q == 8'hE1) begin
          skip_q <= 3'd7;
        end else if (rel_q) begin
          held     <= held & ~held_mask;
          fn_q     <= fn_q & ~fn_hit;
          mod_held <= mod_held & ~mod_hit;
          arrows   <= arrows & ~arrow_hit;
        end else begin
          held     <= held | held_mask;
          fn_q     <= fn_q | fn_hit;
          mod_held <= mod_held | mod_hit;
          arrows   <= arrows | arrow_hit;
        end
      end
    end
  end

  // ------------------------------------------------------------- matrix read
  logic [7:0] rows [8];
  logic [7:0] extra_row;
  logic [7:0] kd;

  // Build the active-low half-rows and select/AND them by address
  always_comb begin
    for (int unsigned r = 0; r < 8; r++) begin
      rows[r] = {3'b111, ~held[r*5 +: 5]};
    end
    rows[0][0]   = ~(mod_held[0] | mod_held[1]);
    rows[7][1]   = ~(mod_held[4] | mod_held[5]);
    rows[0][7:5] = ~fn_q[3:1];
    rows[1][7:5] = ~fn_q[6:4];
    rows[2][7:5] = ~fn_q[9:7];
    rows[3][5]   = ~fn_q[10];
    extra_row    = {3'b111, ~arrows, ~(mod_held[2] | mod_held[3])};
    kd = '1;
    if (bus.addr[15:8] == 8'hFF) begin
      kd = extra_row;
    end else begin
      for (int unsigned r = 0; r < 8; r++) begin
        if (!bus.addr[8 + r]) kd = kd & rows[r];
      end
    end
  end

  assign bus.key_data = kd;
  assign bus.Fn       = fn_q;
  assign bus.mod      = {|mod_held[5:4], |mod_held[3:2], |mod_held[1:0]};
  assign bus.kbd_err  = kbd_err_q;

endmodule

// File: tb/tb_samcoupe_ps2_keyboard.sv
// Directed bench for the SAM Coupe PS/2 keyboard front end.
module tb_samcoupe_ps2_keyboard;

  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 20;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  samcoupe_ps2_keyboard_if kb();

  samcoupe_ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (kb)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  int err_cycles = 0;

  always @(posedge clk_sys) if (kb.kbd_err === 1'b1) err_cycles++;

  typedef struct {
    logic [7:0]  code;
    logic [15:0] addr;
    logic [7:0]  kd;
    logic [10:0] fn;
    logic [2:0]  md;
  } vec_t;

  vec_t vecs[33];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    kb.ps2_kbd_data = b;
    repeat (HALF) @(posedge clk_sys);
    kb.ps2_kbd_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    kb.ps2_kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    kb.ps2_kbd_data = 1'b1;
    repeat (40) @(posedge clk_sys);
  endtask

  task automatic send(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] code, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits - 1; i++) ps2_bit(code[i]);
  endtask

  task automatic do_reset;
    @(negedge clk_sys);
    rst_n = 1'b0;
    kb.ps2_kbd_clk  = 1'b1;
    kb.ps2_kbd_data = 1'b1;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic probe(input string name, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk_sys);
    kb.addr = a;
    #1;
    check(name, {8'h00, kb.key_data}, {8'h00, exp});
  endtask

  int e0;

  initial begin
    kb.ps2_kbd_clk  = 1'b1;
    kb.ps2_kbd_data = 1'b1;
    kb.addr         = 16'hFFFF;

    vecs[0]  = '{8'h1C, 16'hFDFF, 8'hFE, 11'h000, 3'b000};
    vecs[1]  = '{8'hF0, 16'hFDFF, 8'hFE, 11'h000, 3'b000};
    vecs[2]  = '{8'h1C, 16'hFDFF, 8'hFF, 11'h000, 3'b000};
    vecs[3]  = '{8'h1C, 16'hFDFF, 8'hFE, 11'h000, 3'b000};
    vecs[4]  = '{8'h15, 16'hFBFF, 8'hFE, 11'h000, 3'b000};
    vecs[5]  = '{8'h15, 16'h00FF, 8'hFE, 11'h000, 3'b000};
    vecs[6]  = '{8'h1A, 16'hFEFF, 8'hFD, 11'h000, 3'b000};
    vecs[7]  = '{8'h78, 16'hFEFF, 8'hFD, 11'h400, 3'b000};
    vecs[8]  = '{8'h14, 16'hFFFF, 8'hFE, 11'h400, 3'b010};
    vecs[9]  = '{8'hE0, 16'hFFFF, 8'hFE, 11'h400, 3'b010};
    vecs[10] = '{8'h75, 16'hFFFF, 8'hFC, 11'h400, 3'b010};
    vecs[11] = '{8'hF0, 16'hFDFF, 8'hFE, 11'h400, 3'b010};
    vecs[12] = '{8'h1B, 16'hFDFF, 8'hFE, 11'h400, 3'b010};
    vecs[13] = '{8'hE0, 16'hFFFF, 8'hFC, 11'h400, 3'b010};
    vecs[14] = '{8'hF0, 16'hFFFF, 8'hFC, 11'h400, 3'b010};
    vecs[15] = '{8'h75, 16'hFFFF, 8'hFE, 11'h400, 3'b010};
    vecs[16] = '{8'hF0, 16'hFFFF, 8'hFE, 11'h400, 3'b010};
    vecs[17] = '{8'h14, 16'hFFFF, 8'hFF, 11'h400, 3'b000};
    vecs[18] = '{8'hF0, 16'hFEFF, 8'hFD, 11'h400, 3'b000};
    vecs[19] = '{8'h78, 16'hFEFF, 8'hFD, 11'h000, 3'b000};
    vecs[20] = '{8'h05, 16'hFEFF, 8'hDD, 11'h001, 3'b000};
    vecs[21] = '{8'h11, 16'h7FFF, 8'hFD, 11'h001, 3'b100};
    vecs[22] = '{8'hAA, 16'h7FFF, 8'hFD, 11'h001, 3'b100};
    vecs[23] = '{8'hF0, 16'h7FFF, 8'hFD, 11'h001, 3'b100};
    vecs[24] = '{8'h11, 16'h7FFF, 8'hFF, 11'h001, 3'b000};
    vecs[25] = '{8'hE0, 16'hFFFF, 8'hFF, 11'h001, 3'b000};
    vecs[26] = '{8'h14, 16'hFFFF, 8'hFE, 11'h001, 3'b010};
    vecs[27] = '{8'h14, 16'hFFFF, 8'hFE, 11'h001, 3'b010};
    vecs[28] = '{8'hF0, 16'hFFFF, 8'hFE, 11'h001, 3'b010};
    vecs[29] = '{8'h14, 16'hFFFF, 8'hFE, 11'h001, 3'b010};
    vecs[30] = '{8'hE0, 16'hFFFF, 8'hFE, 11'h001, 3'b010};
    vecs[31] = '{8'hF0, 16'hFFFF, 8'hFE, 11'h001, 3'b010};
    vecs[32] = '{8'h14, 16'hFFFF, 8'hFF, 11'h001, 3'b000};

    // Reset state
    #1;
    kb.addr = 16'h00FF;
    #1;
    check("reset_kd_all_rows", {8'h00, kb.key_data}, 16'h00FF);
    check("reset_fn", {5'h00, kb.Fn}, 16'h0000);
    check("reset_mod", {13'h0, kb.mod}, 16'h0000);
    check("reset_err", {15'h0, kb.kbd_err}, 16'h0000);
    kb.addr = 16'hFFFF;
    #1;
    check("reset_kd_extra", {8'h00, kb.key_data}, 16'h00FF);
    do_reset();

    // Table of single-byte steps with cumulative key state
    for (int i = 0; i < 33; i++) begin
      send(vecs[i].code);
      @(negedge clk_sys);
      kb.addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_kd", i), {8'h00, kb.key_data}, {8'h00, vecs[i].kd});
      check($sformatf("vec%0d_fn", i), {5'h00, kb.Fn}, {5'h00, vecs[i].fn});
      check($sformatf("vec%0d_mod", i), {13'h0, kb.mod}, {13'h0, vecs[i].md});
    end
    check("table_no_err", 16'(err_cycles), 16'd0);

    // Parity error: one-cycle pulse, byte dropped
    do_reset();
    e0 = err_cycles;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("parity_err_pulse", 16'(err_cycles - e0), 16'd1);
    probe("parity_err_kd", 16'hFDFF, 8'hFF);

    // Framing error: stop bit low
    e0 = err_cycles;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("stop_err_pulse", 16'(err_cycles - e0), 16'd1);
    probe("stop_err_kd", 16'hFDFF, 8'hFF);

    // Watchdog drops a partial frame silently
    do_reset();
    e0 = err_cycles;
    send_partial(8'h1C, 5);
    kb.ps2_kbd_data = 1'b1;
    repeat (TO + 20) @(posedge clk_sys);
    send(8'h1C);
    probe("timeout_then_a", 16'hFDFF, 8'hFE);
    check("timeout_no_err", 16'(err_cycles - e0), 16'd0);

    // Left/right shift tracked separately
    do_reset();
    send(8'h12);
    send(8'h59);
    send(8'hF0);
    send(8'h12);
    check("shift_one_left_mod", {13'h0, kb.mod}, 16'h0001);
    probe("shift_one_left_kd", 16'hFEFF, 8'hFE);
    send(8'hF0);
    send(8'h59);
    check("shift_none_mod", {13'h0, kb.mod}, 16'h0000);
    probe("shift_none_kd", 16'hFEFF, 8'hFF);

    // Pause sequence: E1 swallows the next seven bytes
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_mod", {13'h0, kb.mod}, 16'h0000);
    probe("pause_extra", 16'hFFFF, 8'hFF);
    send(8'h1C);
    probe("after_pause_a", 16'hFDFF, 8'hFE);

    // Reset mid-frame clears state immediately
    send(8'h78);
    send(8'h14);
    probe("pre_reset_kd", 16'hFDFF, 8'hFE);
    send_partial(8'h1C, 4);
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    check("midreset_kd", {8'h00, kb.key_data}, 16'h00FF);
    check("midreset_fn", {5'h00, kb.Fn}, 16'h0000);
    check("midreset_mod", {13'h0, kb.mod}, 16'h0000);
    kb.ps2_kbd_clk  = 1'b1;
    kb.ps2_kbd_data = 1'b1;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    e0 = err_cycles;
    send(8'h1C);
    probe("post_reset_a", 16'hFDFF, 8'hFE);
    check("post_reset_no_err", 16'(err_cycles - e0), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
